// File: rtl/rgb_mem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : rgb_mem_arbiter_if
// Brief  : Per-master three-channel (R,G,B) SRAM access bus, slice c = [c*W +: W].
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rgb_mem_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic [2:0]      req;
  logic [2:0]      wr;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt;
  logic [2:0]      rvalid;
  logic [3*DW-1:0] rdata;

  modport master (output req, wr, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, wr, addr, wdata, output gnt, rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/rgb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : rgb_mem_arbiter
// Brief  : Two-master arbiter for the R/G/B plane SRAMs; each channel arbitrated
//          independently, round-robin by default, fixed m0 priority with ARB_M0_PRIO_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rgb_mem_arbiter #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             reset,
  rgb_mem_arbiter_if.slave m0,
  rgb_mem_arbiter_if.slave m1,
  output logic [2:0]       mem_wr,
  output logic [3*AW-1:0]  mem_addr,
  output logic [3*DW-1:0]  mem_wdata,
  input  logic [3*DW-1:0]  mem_rdata
);

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic          req0, req1;
    logic          gnt0, gnt1, granted;
    logic          own_d, wr_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic [DW-1:0] mem_rd;

    logic          last_owner_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          rd1_q, own1_q;
    logic          rv0_q, rv1_q;
    logic [DW-1:0] hold0_q, hold1_q;

    assign req0   = m0.req[c];
    assign req1   = m1.req[c];
    assign mem_rd = mem_rdata[c*DW +: DW];

`ifdef ARB_M0_PRIO_EN
    assign gnt0 = req0;
`else
    // last_owner_q=1 means m1 had the previous grant, so m0 wins a tie
    assign gnt0 = req0 & (~req1 | last_owner_q);
`endif
    assign gnt1    = req1 & ~gnt0;
    assign granted = gnt0 | gnt1;

    assign own_d   = gnt1;
    assign wr_d    = gnt1 ? m1.wr[c] : (gnt0 & m0.wr[c]);
    assign addr_d  = gnt1 ? m1.addr[c*AW +: AW]  : m0.addr[c*AW +: AW];
    assign wdata_d = gnt1 ? m1.wdata[c*DW +: DW] : m0.wdata[c*DW +: DW];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        last_owner_q <= 1'b1;
        wr_q         <= 1'b0;
        addr_q       <= '0;
        wdata_q      <= '0;
        rd1_q        <= 1'b0;
        own1_q       <= 1'b0;
        rv0_q        <= 1'b0;
        rv1_q        <= 1'b0;
        hold0_q      <= '0;
        hold1_q      <= '0;
      end else begin
        wr_q <= wr_d;
        if (granted) begin
          last_owner_q <= own_d;
          addr_q       <= addr_d;
          wdata_q      <= wdata_d;
        end
        // Owner tag: stage 1 tracks the cycle the SRAM is addressed, stage 2 the data cycle
        rd1_q  <= granted & ~wr_d;
        own1_q <= own_d;
        rv0_q  <= rd1_q & ~own1_q;
        rv1_q  <= rd1_q & own1_q;
        if (rv0_q) hold0_q <= mem_rd;
        if (rv1_q) hold1_q <= mem_rd;
      end
    end

    assign m0.gnt[c]    = gnt0;
    assign m1.gnt[c]    = gnt1;
    assign m0.rvalid[c] = rv0_q;
    assign m1.rvalid[c] = rv1_q;
    // SRAM output is already a flop stage; forward it in the rvalid cycle, else hold last value
    assign m0.rdata[c*DW +: DW] = rv0_q ? mem_rd : hold0_q;
    assign m1.rdata[c*DW +: DW] = rv1_q ? mem_rd : hold1_q;

    assign mem_wr[c]              = wr_q;
    assign mem_addr[c*AW +: AW]   = addr_q;
    assign mem_wdata[c*DW +: DW]  = wdata_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_rgb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_rgb_mem_arbiter
// Brief  : Directed bench with SRAM model and read-data scoreboard for rgb_mem_arbiter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rgb_mem_arbiter;
  localparam int AW = 14;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rgb_mem_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  rgb_mem_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

  logic [2:0]      mem_wr;
  logic [3*AW-1:0] mem_addr;
  logic [3*DW-1:0] mem_wdata;
  logic [3*DW-1:0] mem_rdata;

  rgb_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if.slave),
    .m1        (m1_if.slave),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous single-port SRAM, write-first
  logic [DW-1:0] sram [3][1<<AW];
  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (mem_wr[c]) begin
        sram[c][mem_addr[c*AW +: AW]] <= mem_wdata[c*DW +: DW];
        mem_rdata[c*DW +: DW]         <= mem_wdata[c*DW +: DW];
      end else begin
        mem_rdata[c*DW +: DW]         <= sram[c][mem_addr[c*AW +: AW]];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int g0cnt = 0;
  int g1cnt = 0;

  typedef struct {
    int            m;
    int            c;
    logic [DW-1:0] d;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  task automatic expect_read(input int m, input int c, input logic [DW-1:0] d);
    exp_t e;
    e.m = m; e.c = c; e.d = d; e.due = cyc + 2;
    exp_q.push_back(e);
  endtask

  // Monitor: every rvalid must match a queued read due this cycle
  logic          mon_v;
  logic [DW-1:0] mon_d;
  int            mon_idx;
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 3; c++) begin
        mon_v = (m == 0) ? m0_if.rvalid[c] : m1_if.rvalid[c];
        mon_d = (m == 0) ? m0_if.rdata[c*DW +: DW] : m1_if.rdata[c*DW +: DW];
        if (mon_v) begin
          mon_idx = -1;
          foreach (exp_q[i])
            if (mon_idx < 0 && exp_q[i].m == m && exp_q[i].c == c && exp_q[i].due == cyc)
              mon_idx = i;
          checks++;
          if (mon_idx < 0) begin
            failures++;
            $display("FAIL rvalid_unexpected m%0d ch%0d cyc=%0d got data=%h, required no rvalid",
                     m, c, cyc, mon_d);
          end else begin
            if (mon_d !== exp_q[mon_idx].d) begin
              failures++;
              $display("FAIL rdata m%0d ch%0d cyc=%0d got %h, required %h",
                       m, c, cyc, mon_d, exp_q[mon_idx].d);
            end
            exp_q.delete(mon_idx);
          end
        end
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL rvalid_missing m%0d ch%0d due cyc=%0d got none, required data=%h",
                 exp_q[i].m, exp_q[i].c, exp_q[i].due, exp_q[i].d);
        exp_q.delete(i);
      end
    end
  end

  task automatic idle();
    m0_if.req = '0;
    m1_if.req = '0;
  endtask

  task automatic drv(input int m, input int c, input logic w,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin
      m0_if.req[c] = 1'b1; m0_if.wr[c] = w;
      m0_if.addr[c*AW +: AW] = a; m0_if.wdata[c*DW +: DW] = d;
    end else begin
      m1_if.req[c] = 1'b1; m1_if.wr[c] = w;
      m1_if.addr[c*AW +: AW] = a; m1_if.wdata[c*DW +: DW] = d;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got %h, required %h", name, got, req);
    end
  endtask

  // Compare grants mid-cycle, then advance to just after the next rising edge
  task automatic chk_gnt(input string name, input logic [2:0] e0, input logic [2:0] e1);
    @(negedge clk);
    checks++;
    if (m0_if.gnt !== e0 || m1_if.gnt !== e1) begin
      failures++;
      $display("FAIL %s got m0_gnt=%b m1_gnt=%b, required m0_gnt=%b m1_gnt=%b",
               name, m0_if.gnt, m1_if.gnt, e0, e1);
    end
    g0cnt += int'(m0_if.gnt[1]);
    g1cnt += int'(m1_if.gnt[1]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    m0_if.req = '0; m0_if.wr = '0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = '0; m1_if.wr = '0; m1_if.addr = '0; m1_if.wdata = '0;

    // 1: reset held with random inputs
    repeat (4) begin
      @(negedge clk);
      m0_if.req = 3'($urandom); m0_if.wr = 3'($urandom);
      m0_if.addr = 42'($urandom); m0_if.wdata = 24'($urandom);
      m1_if.req = 3'($urandom); m1_if.wr = 3'($urandom);
      m1_if.addr = 42'($urandom); m1_if.wdata = 24'($urandom);
    end
    @(negedge clk);
    chk("rst_mem_wr",    64'(mem_wr), 64'h0);
    chk("rst_mem_addr",  64'(mem_addr), 64'h0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    chk("rst_rvalid",    64'({m0_if.rvalid, m1_if.rvalid}), 64'h0);
    chk("rst_rdata",     64'({m0_if.rdata, m1_if.rdata}), 64'h0);
    idle();
    reset = 1'b1;
    @(posedge clk); #1;

    // 3: G contention for 6 cycles; m1 also writes B every cycle unopposed
    g0cnt = 0; g1cnt = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      drv(1, 1, 1'b1, 14'h0020, 8'hB0);
      drv(1, 2, 1'b1, 14'h0005, 8'h33);
`ifdef ARB_M0_PRIO_EN
      if (i < 3) drv(0, 1, 1'b1, 14'h0010, 8'hA0);
      chk_gnt($sformatf("t3_contend_%0d", i), (i < 3) ? 3'b010 : 3'b000,
              (i < 3) ? 3'b100 : 3'b110);
`else
      drv(0, 1, 1'b1, 14'h0010, 8'hA0);
      chk_gnt($sformatf("t3_contend_%0d", i), (i % 2 == 0) ? 3'b010 : 3'b000,
              (i % 2 == 0) ? 3'b100 : 3'b110);
`endif
    end
    chk("t3_m0_count", 64'(g0cnt), 64'd3);
    chk("t3_m1_count", 64'(g1cnt), 64'd3);

    // 2: m0 write R@0x0081 then read back; m1 reads B@0x0005 alongside
    idle(); drv(0, 0, 1'b1, 14'h0081, 8'h5A);
    chk_gnt("t2_write", 3'b001, 3'b000);
    idle(); drv(0, 0, 1'b0, 14'h0081, 8'h00); drv(1, 2, 1'b0, 14'h0005, 8'h00);
    expect_read(0, 0, 8'h5A);
    expect_read(1, 2, 8'h33);
    chk_gnt("t2_read", 3'b001, 3'b100);

    // 4: boundary addresses, concurrent reads on different channels
    idle(); drv(0, 0, 1'b1, 14'h0000, 8'h11); drv(1, 2, 1'b1, 14'h3FFF, 8'hEE);
    chk_gnt("t4_write", 3'b001, 3'b100);
    idle(); drv(0, 0, 1'b0, 14'h0000, 8'h00); drv(1, 2, 1'b0, 14'h3FFF, 8'h00);
    expect_read(0, 0, 8'h11);
    expect_read(1, 2, 8'hEE);
    chk_gnt("t4_read", 3'b001, 3'b100);
    idle();
    repeat (3) chk_gnt("t4_idle", 3'b000, 3'b000);

    // 5: reset asserted the cycle after a granted read; its rvalid must never show
    drv(0, 0, 1'b0, 14'h0081, 8'h00);
    chk_gnt("t5_read", 3'b001, 3'b000);
    idle();
    #2;
    chk("t5_addr_before_rst", 64'(mem_addr[AW-1:0]), 64'h0081);
    reset = 1'b0;
    #1;
    chk("t5_addr_async_clr", 64'(mem_addr), 64'h0);
    chk("t5_rvalid_async_clr", 64'({m0_if.rvalid, m1_if.rvalid}), 64'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_rdata_after_rst", 64'({m0_if.rdata, m1_if.rdata}), 64'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 6: both masters write R continuously, then m0 drops
    for (int i = 0; i < 4; i++) begin
      idle();
      drv(0, 0, 1'b1, 14'h0100, 8'h01);
      drv(1, 0, 1'b1, 14'h0200, 8'h02);
`ifdef ARB_M0_PRIO_EN
      chk_gnt($sformatf("t6_prio_%0d", i), 3'b001, 3'b000);
`else
      chk_gnt($sformatf("t6_rr_%0d", i), (i % 2 == 0) ? 3'b001 : 3'b000,
              (i % 2 == 0) ? 3'b000 : 3'b001);
`endif
    end
    idle(); drv(1, 0, 1'b1, 14'h0200, 8'h02);
    chk_gnt("t6_m0_drop", 3'b000, 3'b001);

    // Read back R and G from both masters; conflict resolves m0 first then m1
    idle();
    drv(0, 0, 1'b0, 14'h0100, 8'h00); drv(0, 1, 1'b0, 14'h0020, 8'h00);
    drv(1, 0, 1'b0, 14'h0200, 8'h00); drv(1, 1, 1'b0, 14'h0010, 8'h00);
    expect_read(0, 0, 8'h01);
    expect_read(0, 1, 8'hB0);
    chk_gnt("rb_m0", 3'b011, 3'b000);
    idle();
    drv(1, 0, 1'b0, 14'h0200, 8'h00); drv(1, 1, 1'b0, 14'h0010, 8'h00);
    expect_read(1, 0, 8'h02);
    expect_read(1, 1, 8'hA0);
    chk_gnt("rb_m1", 3'b000, 3'b011);
    idle();
    repeat (4) chk_gnt("drain_idle", 3'b000, 3'b000);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
